// File: rtl/ysyx_25030093_mem_pkg.sv
// Shared memory-path definitions for the LSU, the SRAM responder and the
// future cache.
//   SZ_B / SZ_H / SZ_W : request size encodings (3 is reserved)
//   state_t            : responder FSM states
//   size_misaligned()  : 1 when size/offset is an illegal access
package ysyx_25030093_mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Reserved size (3) is treated as an error like a misaligned access.
  function automatic logic size_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030093_lane_align.sv
// Byte-lane alignment for a 32-bit word memory.
//   size, off : access size and byte offset (addr[1:0])
//   wdata     : right-aligned store data
//   rword     : full memory word being read
//   wstrb     : per-byte write enables
//   wdata_rep : store data replicated into every lane it may land in
//   rdata     : right-aligned, zero-extended load data
module ysyx_25030093_lane_align
  import ysyx_25030093_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    wstrb     = '0;
    wdata_rep = wdata;
    rdata     = '0;
    shifted   = rword >> {off, 3'b000};
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'h0, shifted[7:0]};
      end
      SZ_H: begin
        wstrb     = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'h0, shifted[15:0]};
      end
      SZ_W: begin
        wstrb = 4'b1111;
        rdata = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_sram_resp.sv
// SRAM responder: slave end of the LSU load/store path.
// Accepts one request at a time, waits LAT cycles, performs a byte-masked
// access to an internal word array, then presents the response until the
// LSU takes it.
//   clk, rst_n         : clock, async active-low reset
//   req_valid/ready    : request handshake
//   req_addr/wen/size/wdata : byte address, store flag, size, store data
//   resp_valid/ready   : response handshake
//   resp_rdata         : zero-extended load data (0 for stores/errors)
//   resp_err           : misaligned address or reserved size
module ysyx_25030093_sram_resp
  import ysyx_25030093_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             mis;
  logic             accept;
  logic             do_access;

  logic [31:0] mem [DEPTH];
  logic [31:0] rword;
  logic [31:0] wrep;
  logic [31:0] rsel;
  logic [3:0]  wstrb;

  // Address bits above the word index are ignored (address wraps).
  logic unused_addr;
  assign unused_addr = ^addr_q[ADDR_W-1:IDX_W+2];

  assign idx       = addr_q[2 +: IDX_W];
  assign off       = addr_q[1:0];
  assign mis       = size_misaligned(size_q, off);
  assign req_ready = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;
  assign do_access = (state == WAIT) && (cnt == '0);
  assign rword     = mem[idx];

  ysyx_25030093_lane_align u_lane_align (
    .size      (size_q),
    .off       (off),
    .wdata     (wdata_q),
    .rword     (rword),
    .wstrb     (wstrb),
    .wdata_rep (wrep),
    .rdata     (rsel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      wen_q   <= req_wen;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  // Response is captured at the access edge and then held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (do_access) begin
      resp_err   <= mis;
      resp_rdata <= (mis || wen_q) ? '0 : rsel;
    end
  end

  // The whole word is written on a single edge; a reset leaves the FSM in
  // IDLE so do_access is low and no partial store can occur.
  always_ff @(posedge clk) begin
    if (do_access && wen_q && !mis) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

endmodule
